ex_div_unit: RTL and testbench

Iterative RV32M divide/remainder unit for the execute stage, consuming the operands and ALU control that the ID/EX pipeline register presents. It accepts one DIV/DIVU/REM/REMU operation per start pulse and computes it with a radix-2 restoring algorithm, one quotient bit per cycle. While it works it tells the hazard logic to stall. A flush from the hazard unit aborts the operation.

---
 rtl/ex_div_unit_if.sv | 24 ++
 rtl/ex_div_unit.sv | 138 +++++++++++++
 tb/tb_ex_div_unit.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/ex_div_unit_if.sv
// Handshake and data bundle between EX control and the divider.
// master: EX side (start/flush/op/a/b out); slave: divider (busy/done/result out).
interface ex_div_unit_if #(
    parameter int DATA_LENGTH = 32
);
    logic                   start;
    logic                   flush;
    logic [1:0]             op;
    logic [DATA_LENGTH-1:0] a;
    logic [DATA_LENGTH-1:0] b;
    logic                   busy;
    logic                   done;
    logic [DATA_LENGTH-1:0] result;

    modport master (
        output start, flush, op, a, b,
        input  busy, done, result
    );

    modport slave (
        input  start, flush, op, a, b,
        output busy, done, result
    );
endinterface

// File: rtl/ex_div_unit.sv
// Iterative radix-2 restoring RV32M DIV/DIVU/REM/REMU unit, one quotient bit per cycle.
// Ports: clk, rst (async active-low), bus (slave: start/flush/op/a/b in, busy/done/result out).
module ex_div_unit #(
    parameter int DATA_LENGTH = 32
) (
    input  logic          clk,
    input  logic          rst,
    ex_div_unit_if.slave  bus
);
    localparam int W  = DATA_LENGTH;
    localparam int CW = $clog2(W);

    typedef enum logic [1:0] {IDLE, CALC, FIN} state_e;

    state_e         state_q, state_d;
    logic [W-1:0]   rem_q, rem_d;
    logic [W-1:0]   dvd_q, dvd_d;
    logic [W-1:0]   dsr_q, dsr_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic           is_rem_q, is_rem_d;
    logic           neg_q, neg_d;
    logic [W-1:0]   result_q, result_d;

    logic           accept;
    logic           signed_op;
    logic           b_zero;
    logic           last_iter;
    logic [W-1:0]   a_abs, b_abs;
    logic [W:0]     sh, dsr_ext, sub;
    logic           ge;
    logic [W-1:0]   rem_nx, quo_nx, res_raw, res_fix;
    logic           busy, done;

    assign accept    = bus.start && !bus.flush;
    assign signed_op = !bus.op[0];
    assign b_zero    = (bus.b == '0);
    assign last_iter = (cnt_q == CW'(W - 1));

    // |-2^31| wraps back to 0x80000000, which is the correct unsigned magnitude.
    assign a_abs = (signed_op && bus.a[W-1]) ? -bus.a : bus.a;
    assign b_abs = (signed_op && bus.b[W-1]) ? -bus.b : bus.b;

    // W+1 bit compare/subtract: the shifted remainder can exceed 2^W-1.
    assign sh      = {rem_q, dvd_q[W-1]};
    assign dsr_ext = {1'b0, dsr_q};
    assign ge      = (sh >= dsr_ext);
    assign sub     = sh - dsr_ext;
    assign rem_nx  = ge ? sub[W-1:0] : sh[W-1:0];
    assign quo_nx  = {dvd_q[W-2:0], ge};
    assign res_raw = is_rem_q ? rem_nx : quo_nx;
    assign res_fix = neg_q ? -res_raw : res_raw;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            rem_q    <= '0;
            dvd_q    <= '0;
            dsr_q    <= '0;
            cnt_q    <= '0;
            is_rem_q <= 1'b0;
            neg_q    <= 1'b0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            rem_q    <= rem_d;
            dvd_q    <= dvd_d;
            dsr_q    <= dsr_d;
            cnt_q    <= cnt_d;
            is_rem_q <= is_rem_d;
            neg_q    <= neg_d;
            result_q <= result_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = b_zero ? FIN : CALC;
                end
            end
            CALC: begin
                if (bus.flush) begin
                    state_d = IDLE;
                end else if (last_iter) begin
                    state_d = FIN;
                end
            end
            FIN:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        rem_d    = rem_q;
        dvd_d    = dvd_q;
        dsr_d    = dsr_q;
        cnt_d    = cnt_q;
        is_rem_d = is_rem_q;
        neg_d    = neg_q;
        result_d = result_q;
        if (state_q == IDLE && accept) begin
            rem_d    = '0;
            cnt_d    = '0;
            dvd_d    = a_abs;
            dsr_d    = b_abs;
            is_rem_d = bus.op[1];
            if (!signed_op) begin
                neg_d = 1'b0;
            end else if (bus.op[1]) begin
                neg_d = bus.a[W-1];
            end else begin
                neg_d = bus.a[W-1] ^ bus.b[W-1];
            end
            // Divide-by-zero bypasses the datapath; no sign fixup applies.
            if (b_zero) begin
                result_d = bus.op[1] ? bus.a : '1;
            end
        end else if (state_q == CALC && !bus.flush) begin
            rem_d = rem_nx;
            dvd_d = quo_nx;
            cnt_d = cnt_q + CW'(1);
            if (last_iter) begin
                result_d = res_fix;
            end
        end
    end

    always_comb begin
        busy = (state_q != IDLE);
        done = (state_q == FIN) && !bus.flush;
    end

    assign bus.busy   = busy;
    assign bus.done   = done;
    assign bus.result = result_q;
endmodule

// File: tb/tb_ex_div_unit.sv
// Directed self-checking bench for ex_div_unit.
// Checks latency, results, divide-by-zero, overflow, flush and async reset.
module tb_ex_div_unit;
    logic clk;
    logic rst;
    int   tests;
    int   failed;

    ex_div_unit_if #(.DATA_LENGTH(32)) bus ();

    ex_div_unit #(.DATA_LENGTH(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Pulse start at a negedge, count negedges until done, check result
    // and that done drops with busy on the following cycle.
    task automatic run_op(input string tag, input logic [1:0] op,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp_res, input int exp_lat);
        int lat;
        lat = 0;
        @(negedge clk);
        bus.start = 1'b1;
        bus.op    = op;
        bus.a     = a;
        bus.b     = b;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            bus.start = 1'b0;
            if (bus.done === 1'b1) begin
                lat = k;
                break;
            end
        end
        check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
        check({tag, "_res"}, bus.result, exp_res);
        @(negedge clk);
        check({tag, "_done_drop"}, {31'd0, bus.done | bus.busy}, 32'd0);
    endtask

    initial begin
        logic [31:0] held;
        tests     = 0;
        failed    = 0;
        rst       = 1'b0;
        bus.start = 1'b0;
        bus.flush = 1'b0;
        bus.op    = 2'b00;
        bus.a     = '0;
        bus.b     = '0;
        repeat (2) @(negedge clk);
        check("rst_busy", {31'd0, bus.busy}, 32'd0);
        check("rst_done", {31'd0, bus.done}, 32'd0);
        check("rst_result", bus.result, 32'd0);
        rst = 1'b1;
        @(negedge clk);

        run_op("divu_100_7", 2'b01, 32'd100, 32'd7, 32'd14, 33);
        run_op("remu_100_7", 2'b11, 32'd100, 32'd7, 32'd2, 33);
        run_op("div_m7_2", 2'b00, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 33);
        run_op("rem_m7_2", 2'b10, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 33);
        run_op("div_20_m3", 2'b00, 32'd20, 32'hFFFF_FFFD, 32'hFFFF_FFFA, 33);
        run_op("rem_20_m3", 2'b10, 32'd20, 32'hFFFF_FFFD, 32'd2, 33);
        run_op("div_ovf", 2'b00, 32'h8000_0000, 32'hFFFF_FFFF,
               32'h8000_0000, 33);
        run_op("rem_ovf", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 33);
        run_op("divu_z", 2'b01, 32'h1234_5678, 32'd0, 32'hFFFF_FFFF, 1);
        run_op("rem_z", 2'b10, 32'h1234_5678, 32'd0, 32'h1234_5678, 1);

        // Flush in the 10th CALC cycle.
        held = 32'h1234_5678;
        @(negedge clk);
        bus.start = 1'b1;
        bus.op    = 2'b01;
        bus.a     = 32'd1000;
        bus.b     = 32'd3;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (9) @(negedge clk);
        check("flush_busy_before", {31'd0, bus.busy}, 32'd1);
        bus.flush = 1'b1;
        @(negedge clk);
        bus.flush = 1'b0;
        check("flush_busy", {31'd0, bus.busy}, 32'd0);
        check("flush_result", bus.result, held);
        begin
            logic seen;
            seen = 1'b0;
            repeat (30) begin
                @(negedge clk);
                if (bus.done === 1'b1) seen = 1'b1;
            end
            check("flush_no_done", {31'd0, seen}, 32'd0);
        end

        // start and flush together in IDLE.
        bus.start = 1'b1;
        bus.flush = 1'b1;
        bus.b     = 32'd0;
        @(negedge clk);
        bus.start = 1'b0;
        bus.flush = 1'b0;
        check("sf_busy", {31'd0, bus.busy}, 32'd0);
        check("sf_done", {31'd0, bus.done}, 32'd0);
        check("sf_result", bus.result, held);

        // Async reset mid-CALC.
        bus.start = 1'b1;
        bus.op    = 2'b01;
        bus.a     = 32'd500;
        bus.b     = 32'd9;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (5) @(negedge clk);
        rst = 1'b0;
        #1;
        check("arst_busy", {31'd0, bus.busy}, 32'd0);
        check("arst_done", {31'd0, bus.done}, 32'd0);
        check("arst_result", bus.result, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        run_op("divu_max_1", 2'b01, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 33);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
